// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory block-copy engine.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} dma_state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_port_mux.sv
// Selects who owns the dmem port: the CPU when sel=0, the copy engine when sel=1.
module dmem_port_mux #(
    parameter int n = 32
) (
    input  logic         sel,
    input  logic         cpu_memWrite,
    input  logic [n-1:0] cpu_addr,
    input  logic [n-1:0] cpu_writeData,
    input  logic         eng_memWrite,
    input  logic [n-1:0] eng_addr,
    input  logic [n-1:0] eng_writeData,
    output logic         mem_memWrite,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_writeData
);

    // CPU writes are dropped entirely while the engine owns the port.
    assign mem_memWrite  = sel ? eng_memWrite  : cpu_memWrite;
    assign mem_addr      = sel ? eng_addr      : cpu_addr;
    assign mem_writeData = sel ? eng_writeData : cpu_writeData;

endmodule

// File: rtl/dmem_dma.sv
// Block-copy initiator on the dmem single port: copies len words src->dst, ascending,
// two cycles per word; the CPU owns the port whenever the engine is idle.
module dmem_dma
    import dmem_pkg::*;
#(
    parameter int n = 32,
    parameter int r = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] src_addr,
    input  logic [n-1:0] dst_addr,
    input  logic [r:0]   len,
    output logic         busy,
    output logic         done,
    input  logic         cpu_memWrite,
    input  logic [n-1:0] cpu_addr,
    input  logic [n-1:0] cpu_writeData,
    output logic [n-1:0] cpu_readData,
    output logic         mem_memWrite,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_writeData,
    input  logic [n-1:0] mem_readData
);

    localparam logic [n-1:0] ALIGN_MASK = ~n'(WORD_BYTES - 1);
    localparam logic [n-1:0] STEP       = n'(WORD_BYTES);

    dma_state_t   state, state_nx;
    logic [n-1:0] src, dst, dbuf;
    logic [r:0]   cnt;
    logic         eng_memWrite;
    logic [n-1:0] eng_addr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            src   <= '0;
            dst   <= '0;
            cnt   <= '0;
            dbuf  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    src <= src_addr & ALIGN_MASK;
                    dst <= dst_addr & ALIGN_MASK;
                    cnt <= len;
                end
                READ: begin
                    dbuf <= mem_readData;
                    src  <= src + STEP;
                end
                WRITE: begin
                    dst <= dst + STEP;
                    cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx     = state;
        eng_memWrite = 1'b0;
        eng_addr     = dst;
        done         = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = (len == '0) ? DONE : READ;
            READ: begin
                eng_addr = src;
                state_nx = WRITE;
            end
            WRITE: begin
                eng_memWrite = 1'b1;
                state_nx     = (cnt == (r+1)'(1)) ? DONE : READ;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy         = (state != IDLE);
    assign cpu_readData = mem_readData;

    dmem_port_mux #(.n(n)) u_port_mux (
        .sel           (busy),
        .cpu_memWrite  (cpu_memWrite),
        .cpu_addr      (cpu_addr),
        .cpu_writeData (cpu_writeData),
        .eng_memWrite  (eng_memWrite),
        .eng_addr      (eng_addr),
        .eng_writeData (dbuf),
        .mem_memWrite  (mem_memWrite),
        .mem_addr      (mem_addr),
        .mem_writeData (mem_writeData)
    );

endmodule

// File: tb/tb_dmem_dma.sv
// Bench for dmem_dma with a behavioural 128-word dmem and an array-level copy model.
module tb_dmem_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [7:0]  len;
    logic        busy, done;
    logic        cpu_memWrite;
    logic [31:0] cpu_addr, cpu_writeData, cpu_readData;
    logic        mem_memWrite;
    logic [31:0] mem_addr, mem_writeData, mem_readData;

    always #5 clk = ~clk;

    dmem_dma #(.n(32), .r(7)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .cpu_memWrite  (cpu_memWrite),
        .cpu_addr      (cpu_addr),
        .cpu_writeData (cpu_writeData),
        .cpu_readData  (cpu_readData),
        .mem_memWrite  (mem_memWrite),
        .mem_addr      (mem_addr),
        .mem_writeData (mem_writeData),
        .mem_readData  (mem_readData)
    );

    // dmem: combinational read, write on posedge, index bits above [8:2] ignored
    logic [31:0] mem [128];
    always @(posedge clk) if (mem_memWrite) mem[mem_addr[8:2]] <= mem_writeData;
    assign mem_readData = mem[mem_addr[8:2]];

    logic [31:0] ref_mem [128];
    int checks = 0;
    int errors = 0;

    int done_first, done_cnt, we_cnt, misalign, busy_after, rst_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input int unsigned widx, input logic [31:0] data);
        @(negedge clk);
        cpu_addr      = 32'(widx) << 2;
        cpu_writeData = data;
        cpu_memWrite  = 1'b1;
        @(negedge clk);
        cpu_memWrite  = 1'b0;
        ref_mem[widx % 128] = data;
    endtask

    task automatic cpu_read(input int unsigned widx, output logic [31:0] d);
        @(negedge clk);
        cpu_addr = 32'(widx) << 2;
        #1 d = cpu_readData;
    endtask

    task automatic verify_mem(input string tag);
        logic [31:0] d;
        for (int i = 0; i < 128; i++) begin
            cpu_read(i, d);
            check($sformatf("%s_word%0d", tag, i), d, ref_mem[i]);
        end
    endtask

    // Word-by-word ascending copy; overlapping ranges naturally propagate.
    task automatic ref_copy(input logic [31:0] s, input logic [31:0] d, input int l);
        int unsigned sw, dw;
        sw = s >> 2;
        dw = d >> 2;
        for (int i = 0; i < l; i++)
            ref_mem[(dw + i) % 128] = ref_mem[(sw + i) % 128];
    endtask

    // Issues one copy and monitors it for a bounded number of cycles; cycle 0 is the start edge.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int l,
                            input int pulse_cyc, input int restart_cyc, input int rst_cyc);
        done_first = -1; done_cnt = 0; we_cnt = 0; misalign = 0; busy_after = -1; rst_busy = -1;
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = 8'(l);
        start    = 1'b1;
        for (int cyc = 1; cyc <= 2 * l + 4; cyc++) begin
            @(negedge clk);
            start        = 1'b0;
            cpu_memWrite = 1'b0;
            rst          = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_first < 0) done_first = cyc;
            end
            if (done_first >= 0 && cyc == done_first + 1) busy_after = int'(busy);
            if (cyc == rst_cyc + 1) rst_busy = int'(busy);
            if (mem_memWrite) we_cnt++;
            if (busy && mem_addr[1:0] != 2'b00) misalign++;
            if (cyc == pulse_cyc) begin
                cpu_addr      = 32'h100;
                cpu_writeData = 32'hDEAD_BEEF;
                cpu_memWrite  = 1'b1;
            end
            if (cyc == restart_cyc) begin
                src_addr = 32'h0;
                dst_addr = 32'h10;
                len      = 8'd1;
                start    = 1'b1;
            end
            if (cyc == rst_cyc) rst = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] s, t;
        int l, nw;

        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        cpu_memWrite = 1'b0; cpu_addr = '0; cpu_writeData = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Idle passthrough
        @(negedge clk);
        cpu_addr = 32'h1234_5678; cpu_writeData = 32'hCAFE_F00D;
        #1;
        check("idle_pass_addr", mem_addr, 32'h1234_5678);
        check("idle_pass_wdata", mem_writeData, 32'hCAFE_F00D);
        check("idle_pass_we0", 32'(mem_memWrite), 32'd0);
        cpu_memWrite = 1'b1;
        #1;
        check("idle_pass_we1", 32'(mem_memWrite), 32'd1);
        check("readdata_pass", cpu_readData, mem_readData);
        cpu_memWrite = 1'b0;

        // Preload whole memory with random words
        for (int i = 0; i < 128; i++) cpu_write(i, $urandom);
        for (int i = 0; i < 4; i++) cpu_write(i, 32'hA0A0_0000 + 32'(i));

        // 1: basic 4-word copy
        run_copy(32'h0, 32'h40, 4, -1, -1, -1);
        ref_copy(32'h0, 32'h40, 4);
        check("t1_done_cycle", 32'(done_first), 32'd9);
        check("t1_done_count", 32'(done_cnt), 32'd1);
        check("t1_busy_after", 32'(busy_after), 32'd0);
        check("t1_write_count", 32'(we_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            cpu_read(16 + i, d);
            check($sformatf("t1_dst%0d", i), d, 32'hA0A0_0000 + 32'(i));
        end
        verify_mem("t1");

        // 2: zero length
        run_copy(32'h0, 32'h8, 0, -1, -1, -1);
        check("t2_done_cycle", 32'(done_first), 32'd1);
        check("t2_done_count", 32'(done_cnt), 32'd1);
        check("t2_write_count", 32'(we_cnt), 32'd0);
        verify_mem("t2");

        // 3: CPU write and re-start during a copy are ignored
        run_copy(32'h80, 32'h180, 8, 3, 5, -1);
        ref_copy(32'h80, 32'h180, 8);
        check("t3_done_cycle", 32'(done_first), 32'd17);
        check("t3_done_count", 32'(done_cnt), 32'd1);
        check("t3_write_count", 32'(we_cnt), 32'd8);
        verify_mem("t3");

        // 4: low address bits ignored
        run_copy(32'h3, 32'h21, 2, -1, -1, -1);
        ref_copy(32'h0, 32'h20, 2);
        check("t4_misaligned", 32'(misalign), 32'd0);
        check("t4_done_cycle", 32'(done_first), 32'd5);
        verify_mem("t4");

        // 5: reset during WRITE of the third word
        for (int i = 0; i < 6; i++) cpu_write(48 + i, ~ref_mem[32 + i]);
        run_copy(32'h80, 32'hC0, 6, -1, -1, 6);
        nw = 0;
        for (int i = 0; i < 6; i++) begin
            cpu_read(48 + i, d);
            if (d === ref_mem[32 + i] && nw == i) nw++;
        end
        check("t5_words_written_2_or_3", 32'(nw == 2 || nw == 3), 32'd1);
        check("t5_busy_after_rst", 32'(rst_busy), 32'd0);
        check("t5_no_done", 32'(done_cnt), 32'd0);
        ref_copy(32'h80, 32'hC0, nw);
        verify_mem("t5");

        // 6: source wraps past the top of memory; overlap propagates
        d = ref_mem[127];
        run_copy(32'h1FC, 32'h0, 2, -1, -1, -1);
        ref_copy(32'h1FC, 32'h0, 2);
        check("t6_model_word0", ref_mem[0], d);
        check("t6_model_word1", ref_mem[1], d);
        verify_mem("t6");

        // Randomized copies, including full-memory length and 32-bit address wrap
        for (int k = 0; k < 5; k++) begin
            s = $urandom;
            t = $urandom;
            l = (k == 0) ? 128 : int'($urandom_range(1, 127));
            if (k == 1) s = 32'hFFFF_FFFC;
            run_copy(s, t, l, -1, -1, -1);
            ref_copy(s, t, l);
            check($sformatf("rnd%0d_done_cycle", k), 32'(done_first), 32'(2 * l + 1));
            check($sformatf("rnd%0d_done_count", k), 32'(done_cnt), 32'd1);
            check($sformatf("rnd%0d_write_count", k), 32'(we_cnt), 32'(l));
            check($sformatf("rnd%0d_misaligned", k), 32'(misalign), 32'd0);
            verify_mem($sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
